// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus bundle shared by the core (master) and the MMIO responder (slave).
interface dmem_mmio_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   dmem_addr;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_wstrb;
    logic                    dmem_write;
    logic                    dmem_read;
    logic [DATA_WIDTH-1:0]   dmem_rdata;
    logic                    mmio_hit;

    modport master (
        output dmem_addr, dmem_wdata, dmem_wstrb, dmem_write, dmem_read,
        input  dmem_rdata, mmio_hit
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_wstrb, dmem_write, dmem_read,
        output dmem_rdata, mmio_hit
    );
endinterface

// File: rtl/dmem_mmio_responder.sv
// MMIO responder beside the data memory: TOHOST completion, character FIFO, cycle counter
// with coherent high snapshot, scratch. Optional watchdog enabled by macro MMIO_TIMEOUT_EN.
module dmem_mmio_responder #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0001_0000,
    parameter int                    FIFO_DEPTH     = 8,
    parameter int                    TIMEOUT_CYCLES = 100000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dmem_mmio_responder_if.slave        bus,
    output logic                        char_valid,
    output logic [7:0]                  char_data,
    input  logic                        char_ready,
    output logic                        test_done,
    output logic                        test_pass,
    output logic [30:0]                 exit_code
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("dmem_mmio_responder: DATA_WIDTH must be 32");
        end
        if (BASE_ADDR[4:0] != 5'd0) begin : g_bad_base
            $error("dmem_mmio_responder: BASE_ADDR must be 32-byte aligned");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("dmem_mmio_responder: FIFO_DEPTH must be a power of two >= 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("dmem_mmio_responder: TIMEOUT_CYCLES must be positive");
        end
    endgenerate

    localparam int          PTR_W        = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  OFF_TOHOST   = 5'h00;
    localparam logic [4:0]  OFF_CHAR_TX  = 5'h04;
    localparam logic [4:0]  OFF_STATUS   = 5'h08;
    localparam logic [4:0]  OFF_CYCLE_LO = 5'h0C;
    localparam logic [4:0]  OFF_CYCLE_HI = 5'h10;
    localparam logic [4:0]  OFF_SCRATCH  = 5'h14;
    localparam logic [31:0] PASS_MAGIC   = 32'hDEAD_BEEF;

    logic             hit;
    logic [4:0]       offset;
    logic             wr_en;
    logic             rd_en;
    logic             tohost_wr;
    logic             tohost_complete;
    logic             tohost_pass;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             ovf_clear;
    logic             lo_read;
    logic             scratch_wr;
    logic             timeout_fire;

    logic [31:0]      tohost_q;
    logic [31:0]      scratch_q;
    logic [31:0]      hi_shadow_q;
    logic [63:0]      cycle_cnt;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic             fifo_empty;
    logic             fifo_full;
    logic             overflow_q;
    logic             timeout_q;
    logic [31:0]      rdata;

    // Address decode and per-register access strobes
    assign hit    = (bus.dmem_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign offset = bus.dmem_addr[4:0];
    assign wr_en  = bus.dmem_write & hit;
    assign rd_en  = bus.dmem_read & hit;

    assign tohost_wr       = wr_en && (offset == OFF_TOHOST) && (|bus.dmem_wstrb);
    assign tohost_complete = tohost_wr && !test_done && (bus.dmem_wdata != '0);
    assign tohost_pass     = (bus.dmem_wdata == 32'h1) || (bus.dmem_wdata == PASS_MAGIC);
    assign push_req        = wr_en && (offset == OFF_CHAR_TX) && bus.dmem_wstrb[0];
    assign ovf_clear       = wr_en && (offset == OFF_STATUS) && bus.dmem_wstrb[0] && bus.dmem_wdata[3];
    assign lo_read         = rd_en && (offset == OFF_CYCLE_LO);
    assign scratch_wr      = wr_en && (offset == OFF_SCRATCH);

    assign bus.mmio_hit = hit;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && char_ready;
    assign push       = push_req && (!fifo_full || pop);
    assign char_valid = !fifo_empty;
    assign char_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is reset as well so every registered bit comes up 0; the array is small.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= 8'h00;
        end else if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.dmem_wdata[7:0];
        end
    end

    // A dropped byte in the same cycle as a clear leaves overflow set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end else if (ovf_clear) begin
            overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            hi_shadow_q <= '0;
        end else begin
            if (!test_done) cycle_cnt <= cycle_cnt + 64'd1;
            if (lo_read)    hi_shadow_q <= cycle_cnt[63:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_q  <= '0;
            scratch_q <= '0;
        end else begin
            if (tohost_wr) tohost_q <= bus.dmem_wdata;
            if (scratch_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.dmem_wstrb[b]) scratch_q[8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    // A completing TOHOST write in the same cycle wins over the watchdog
    assign timeout_fire = !test_done && !tohost_complete &&
                          (cycle_cnt == 64'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else if (timeout_fire) begin
            timeout_q <= 1'b1;
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign timeout_q    = 1'b0;
`endif

    // Result is captured once; later TOHOST writes only change the readback value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test_done <= 1'b0;
            test_pass <= 1'b0;
            exit_code <= '0;
        end else if (!test_done) begin
            if (tohost_complete) begin
                test_done <= 1'b1;
                test_pass <= tohost_pass;
                if (!tohost_pass) exit_code <= bus.dmem_wdata[31:1];
            end else if (timeout_fire) begin
                test_done <= 1'b1;
                test_pass <= 1'b0;
                exit_code <= 31'h7FFF_FFFF;
            end
        end
    end

    always_comb begin
        // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
        rdata = '0;
        if (rd_en) begin
            case (offset)
                OFF_TOHOST:   rdata = tohost_q;
                OFF_STATUS:   rdata = {27'b0, timeout_q, overflow_q, fifo_full, fifo_empty, test_done};
                OFF_CYCLE_LO: rdata = cycle_cnt[31:0];
                OFF_CYCLE_HI: rdata = hi_shadow_q;
                OFF_SCRATCH:  rdata = scratch_q;
                default:      rdata = '0;
            endcase
        end
    end

    assign bus.dmem_rdata = rdata;

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Memory-mapped responder on the core's data-memory bus (dmem_addr/wdata/wstrb/write/read/rdata), sitting beside the data memory as a second target.
- Provides a tohost test-completion register, a character-output FIFO, a 64-bit cycle counter with a coherent snapshot, and a scratch register.
- Top level uses mmio_hit to steer dmem_rdata between this block and the data memory, and to suppress memory writes.
- Lets benches and firmware signal pass/fail and print without probing internal core signals.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width. Fixed at 32; any other value is a compile-time error.
- BASE_ADDR, 32'h0001_0000, base of the 32-byte MMIO window. Must be 32-byte aligned.
- FIFO_DEPTH, 8, character FIFO entries. Power of two, at least 2.
- TIMEOUT_CYCLES, 100000, watchdog limit. Used only with MMIO_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- dmem_addr  in  ADDR_WIDTH  byte address from the core.
- dmem_wdata  in  DATA_WIDTH  write data.
- dmem_wstrb  in  DATA_WIDTH/8  byte write strobes.
- dmem_write  in  1  write request.
- dmem_read  in  1  read request.
- dmem_rdata  out  DATA_WIDTH  read data, combinational.
- mmio_hit  out  1  high when dmem_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]; combinational.
- char_valid  out  1  FIFO not empty.
- char_data  out  8  FIFO head byte.
- char_ready  in  1  consumer pops the head when char_valid & char_ready at a clock edge.
- test_done  out  1  sticky completion flag.
- test_pass  out  1  result; meaningful only while test_done is high.
- exit_code  out  31  failure code.

Behaviour:
- Access timing: zero-latency. Reads are combinational (dmem_rdata valid in the same cycle as the address). Writes take effect at the next clock edge when dmem_write & mmio_hit.
- dmem_rdata is 0 when there is no mmio_hit or dmem_read is low.
- Register map (offset = dmem_addr[4:0], word aligned; unaligned or unlisted offsets read 0 and ignore writes):
  - 0x00 TOHOST: R returns last written value. W with any strobe set latches the full wdata word.
    - Only if test_done is 0, the latched value is also decoded:
      - nonzero value -> test_done=1.
      - test_pass=1 if value==1 or value==32'hDEADBEEF.
      - otherwise test_pass=0, exit_code=value[31:1].
      - value 0 -> latched, but no completion.
    - Writes after done update only the readback value; done/pass/code stay frozen.
  - 0x04 CHAR_TX: W with wstrb[0]=1 pushes wdata[7:0]; wstrb[0]=0 is ignored. R returns 0.
  - 0x08 STATUS: R returns {27'b0, timeout, overflow, full, empty, test_done}. W with wdata[3]=1 and wstrb[0]=1 clears overflow (W1C); other bits are read-only.
  - 0x0C CYCLE_LO: R returns live counter[31:0]. A read access (dmem_read & hit at this offset) latches counter[63:32] into hi_shadow at the clock edge.
  - 0x10 CYCLE_HI: R returns hi_shadow.
  - 0x14 SCRATCH: R/W with per-byte wstrb.
- Cycle counter: 64-bit; increments every cycle out of reset; freezes once test_done=1; wraps to 0 after all-ones.
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit read/write pointers; full/empty derived from the pointers.
  - Push while full with no pop in the same cycle -> byte dropped, overflow set (sticky).
  - Push and pop in the same cycle while full -> both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty -> push only; char_valid rises the next cycle.
  - No pop when empty.
- Reset (asynchronous, any time, including mid-access or mid-drain) clears:
  - FIFO pointers, overflow, timeout.
  - TOHOST, SCRATCH, hi_shadow, cycle counter.
  - Output values after reset: test_done=0, test_pass=0, exit_code=0, char_valid=0, char_data=0.
- Reset value of all registered state: 0.

Optional Feature:
- Macro MMIO_TIMEOUT_EN.
- Defined:
  - Watchdog compares the cycle counter with TIMEOUT_CYCLES.
  - When counter == TIMEOUT_CYCLES-1 and test_done=0, at that edge: test_done=1, test_pass=0, exit_code=31'h7FFF_FFFF, timeout=1.
  - A TOHOST write in the same cycle has priority; timeout then stays 0.
- Undefined: no watchdog logic; the STATUS timeout bit reads 0.

Test Plan:
- Reset, then write TOHOST=1 at BASE+0x00 -> next cycle test_done=1, test_pass=1; a later write of 5 leaves pass=1 and exit_code=0, and TOHOST reads 5.
- Write TOHOST=32'h0000_0007 -> test_done=1, test_pass=0, exit_code=3. Separately, TOHOST=32'hDEADBEEF -> pass=1.
- Push 9 bytes 0x41..0x49 to CHAR_TX with char_ready=0 (FIFO_DEPTH=8) -> STATUS reads 0x0C (full, overflow). Drain gives 0x41..0x48 in order, then char_valid=0. Write STATUS 0x08 -> overflow clears.
- FIFO full, push 0x5A with char_ready=1 in the same cycle -> no overflow; 0x5A is the last byte drained.
- Run past 2^32 cycles (or force the counter to 0x0000_0000_FFFF_FFFE) -> reading LO then HI returns a coherent pair; HI equals the upper word at the LO-read edge.
- Assert rst_n low mid-drain with 3 bytes queued -> char_valid, test_done, and all registers read 0 immediately. With MMIO_TIMEOUT_EN, TIMEOUT_CYCLES=50 and no TOHOST write -> test_done=1, exit_code=31'h7FFF_FFFF, STATUS bit4=1.
